// File: rtl/dft_pkg.sv
// Shared types for the sliding-DFT sample path: complex sample format and feeder FSM states.
package dft_pkg;

   localparam int unsigned WIDTH = 12;

   typedef logic signed [WIDTH-1:0] sample_t;
   typedef sample_t [0:1]           cplx_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } feeder_state_t;

endpackage

// File: rtl/dft_sample_feeder_if.sv
// Sample handshake from the front end plus the write/done pair towards the DFT core.
interface dft_sample_feeder_if;
   import dft_pkg::*;

   cplx_t i_x;
   logic  i_valid;
   logic  o_ready;
   cplx_t o_x;
   logic  o_wr;
   logic  i_done;

   modport slave (
      input  i_x, i_valid, i_done,
      output o_ready, o_x, o_wr
   );

   modport master (
      output i_x, i_valid, i_done,
      input  o_ready, o_x, o_wr
   );

endinterface

// File: rtl/dft_sample_fifo.sv
// Synchronous sample FIFO with occupancy count and a flush that empties it in one cycle.
module dft_sample_fifo
   import dft_pkg::*;
#(
   parameter  int unsigned DEPTH     = 16,
   localparam int unsigned LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  cplx_t              wdata_i,
   output cplx_t              rdata_c_o,
   output logic [LOG_DEPTH:0] count_o,
   output logic               full_c_o,
   output logic               empty_c_o
);

   localparam logic [LOG_DEPTH:0]   FULL_CNT = (LOG_DEPTH+1)'(DEPTH);
   localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
   localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);

   cplx_t                mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 push_ok, pop_ok;

   assign full_c_o  = (count_q == FULL_CNT);
   assign empty_c_o = (count_q == '0);
   assign push_ok   = push_i && !full_c_o && !flush_i;
   assign pop_ok    = pop_i && !empty_c_o;
   assign rdata_c_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dft_sample_feeder.sv
// Buffers complex samples and hands them to the DFT one at a time, waiting for busy-then-done.
module dft_sample_feeder
   import dft_pkg::*;
#(
   parameter  int unsigned DEPTH        = 16,
   parameter  int unsigned BUSY_TIMEOUT = 8,
   localparam int unsigned LOG_DEPTH    = $clog2(DEPTH)
) (
   input  logic                i_sys_clk,
   input  logic                i_sys_rst,
   dft_sample_feeder_if.slave  dft_if,
   input  logic                i_flush,
   input  logic                i_clr,
   output logic [LOG_DEPTH:0]  o_count,
   output logic                o_overflow
);

   localparam int unsigned      TMO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   feeder_state_t    state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   cplx_t            x_q, x_d;
   logic             wr_q, wr_d;
   logic             ovf_q, ovf_d;

   cplx_t head;
   logic  full, empty;
   logic  push, pop;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign dft_if.o_ready = !full && !i_flush;
   assign push           = dft_if.i_valid && dft_if.o_ready;

   dft_sample_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (i_sys_clk),
      .rst_ni    (i_sys_rst),
      .flush_i   (i_flush),
      .push_i    (push),
      .pop_i     (pop),
      .wdata_i   (dft_if.i_x),
      .rdata_c_o (head),
      .count_o   (o_count),
      .full_c_o  (full),
      .empty_c_o (empty)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      x_d     = x_q;
      wr_d    = 1'b0;
      ovf_d   = ovf_q;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!empty && dft_if.i_done) begin
               pop     = 1'b1;
               x_d     = head;
               wr_d    = 1'b1;
               tmo_d   = '0;
               state_d = WAIT_BUSY;
            end
         end
         // A DFT that never drops done is assumed to have finished inside the window.
         WAIT_BUSY: begin
            if (!dft_if.i_done) begin
               state_d = WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
         end
         WAIT_DONE: begin
            if (dft_if.i_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (i_clr) ovf_d = 1'b0;
      if (dft_if.i_valid && !dft_if.o_ready) ovf_d = 1'b1;
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         x_q     <= '0;
         wr_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         x_q     <= x_d;
         wr_q    <= wr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign dft_if.o_x = x_q;
   assign dft_if.o_wr = wr_q;
   assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Directed bench: expected samples queued at push, checked by a monitor on every o_wr.
module tb_dft_sample_feeder;
   import dft_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned BT    = 8;

   logic                    clk   = 1'b0;
   logic                    rst_n = 1'b1;
   logic                    flush = 1'b0;
   logic                    clr   = 1'b0;
   logic [$clog2(DEPTH):0]  count;
   logic                    ovf;
   logic                    man_done   = 1'b1;
   logic                    model_done = 1'b1;

   typedef enum {M_MAN, M_RESP} mode_t;
   mode_t mode = M_MAN;

   dft_sample_feeder_if ifc ();
   assign ifc.i_done = (mode == M_RESP) ? model_done : man_done;

   dft_sample_feeder #(
      .DEPTH        (DEPTH),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .i_sys_clk  (clk),
      .i_sys_rst  (rst_n),
      .dft_if     (ifc),
      .i_flush    (flush),
      .i_clr      (clr),
      .o_count    (count),
      .o_overflow (ovf)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad   = 0;
   cplx_t sb [$];
   int    wr_cnt      = 0;
   int    cyc         = 0;
   int    last_wr_cyc = 0;
   bit    have_prev   = 0;
   bit    gap_en      = 0;

   function automatic cplx_t mk(input int re, input int im);
      cplx_t v;
      v[0] = sample_t'(re);
      v[1] = sample_t'(im);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // DFT model: done drops one cycle after a write and rises again four cycles later.
   initial begin
      int low;
      bit pend;
      low  = 0;
      pend = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || mode != M_RESP) begin
            pend       = 0;
            low        = 0;
            model_done = 1'b1;
         end else begin
            if (pend) begin
               model_done = 1'b0;
               low        = 4;
               pend       = 0;
            end else if (low != 0) begin
               low--;
               if (low == 0) model_done = 1'b1;
            end
            if (ifc.o_wr) pend = 1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && ifc.o_wr) begin
         wr_cnt++;
         if (gap_en && have_prev) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(BT + 1));
         have_prev   = 1;
         last_wr_cyc = cyc;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_unexpected: o_x=%h with no sample pending", ifc.o_x);
         end else begin
            chk("o_x_order", 32'(ifc.o_x), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic push(input int re, input int im, input bit exp_acc, input bit fl = 1'b0);
      cplx_t v;
      v = mk(re, im);
      @(posedge clk);
      #1;
      ifc.i_x     = v;
      ifc.i_valid = 1'b1;
      flush       = fl;
      #1;
      chk("o_ready", 32'(ifc.o_ready), 32'(exp_acc));
      if (exp_acc) sb.push_back(v);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      ifc.i_valid = 1'b0;
      flush       = 1'b0;
      clr         = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_wr(input int target, input int budget, input string nm);
      for (int i = 0; i < budget && wr_cnt < target; i++) settle();
      chk(nm, 32'(wr_cnt), 32'(target));
   endtask

   initial begin
      int base;
      ifc.i_valid = 1'b0;
      ifc.i_x     = '0;

      // 1: async reset, then reset again mid-operation
      #3 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(ifc.o_ready), 32'd1);
      chk("rst_wr", 32'(ifc.o_wr), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      push(7, -8, 1'b1);
      idle();
      wait_wr(1, 20, "t1_wr");
      man_done = 1'b0;
      push(1, 2, 1'b1);
      push(3, 4, 1'b1);
      idle();
      settle();
      chk("t1_count", 32'(count), 32'd2);
      chk("t1_hold", 32'(ifc.o_x), 32'(mk(7, -8)));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t1_mid_count", 32'(count), 32'd0);
      chk("t1_mid_ready", 32'(ifc.o_ready), 32'd1);
      chk("t1_mid_wr", 32'(ifc.o_wr), 32'd0);
      chk("t1_mid_x", 32'(ifc.o_x), 32'd0);
      sb.delete();
      man_done = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // 2: single sample through a responsive DFT
      mode = M_RESP;
      base = wr_cnt;
      push(100, -5, 1'b1);
      idle();
      wait_wr(base + 1, 20, "t2_wr");
      repeat (12) settle();
      chk("t2_single", 32'(wr_cnt), 32'(base + 1));
      chk("t2_count", 32'(count), 32'd0);
      chk("t2_x", 32'(ifc.o_x), 32'(mk(100, -5)));

      // 3: burst held off by done low, then drained in order
      mode     = M_MAN;
      man_done = 1'b0;
      base     = wr_cnt;
      for (int i = 0; i < 5; i++) push(i * 37 - 50, 200 - i * 3, 1'b1);
      idle();
      repeat (3) settle();
      chk("t3_count", 32'(count), 32'd5);
      chk("t3_nowr", 32'(wr_cnt), 32'(base));
      mode = M_RESP;
      wait_wr(base + 5, 100, "t3_drain");
      repeat (8) settle();
      chk("t3_empty", 32'(count), 32'd0);

      // 4: fill, overflow, clear, set-wins-over-clear, drain
      mode     = M_MAN;
      man_done = 1'b0;
      base     = wr_cnt;
      for (int i = 0; i < 16; i++) push(i * 100 - 800, 2047 - i, 1'b1);
      push(-2048, -1, 1'b0);
      idle();
      settle();
      chk("t4_full", 32'(count), 32'd16);
      chk("t4_ovf", 32'(ovf), 32'd1);
      @(posedge clk);
      #1 clr = 1'b1;
      idle();
      settle();
      chk("t4_clr", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
      ifc.i_x     = mk(5, 5);
      ifc.i_valid = 1'b1;
      clr         = 1'b1;
      idle();
      settle();
      chk("t4_set_wins", 32'(ovf), 32'd1);
      @(posedge clk);
      #1 clr = 1'b1;
      idle();
      mode = M_RESP;
      wait_wr(base + 16, 300, "t4_drain");
      repeat (8) settle();
      chk("t4_empty", 32'(count), 32'd0);
      chk("t4_ovf_off", 32'(ovf), 32'd0);

      // 5: done stuck high, writes paced by the busy timeout
      mode      = M_MAN;
      man_done  = 1'b1;
      have_prev = 0;
      gap_en    = 1;
      base      = wr_cnt;
      push(-1, 1, 1'b1);
      push(2047, -2048, 1'b1);
      push(0, 0, 1'b1);
      idle();
      wait_wr(base + 3, 60, "t5_wr");
      gap_en = 0;
      repeat (12) settle();

      // 6: flush plus push while a write waits for done
      base = wr_cnt;
      push(300, -300, 1'b1);
      idle();
      wait_wr(base + 1, 20, "t6_wr");
      man_done = 1'b0;
      push(11, 12, 1'b1);
      push(13, 14, 1'b1);
      push(15, 16, 1'b0, 1'b1);
      sb.delete();
      idle();
      settle();
      chk("t6_flushed", 32'(count), 32'd0);
      chk("t6_ovf", 32'(ovf), 32'd1);
      man_done = 1'b1;
      repeat (20) settle();
      chk("t6_nowr", 32'(wr_cnt), 32'(base + 1));
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_x", 32'(ifc.o_x), 32'(mk(300, -300)));
      chk("t6_sb", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
